queue_dispatcher: RTL and testbench
===================================

// Module: queue_dispatcher
// PURPOSE
// - Stage directly downstream of the randomised fixed-priority queue selector.
// - Consumes the selector's valid/selection pair and pops one entry from the selected
//   first-word-fall-through (FWFT) request queue.
// - Presents the popped entry on a valid/ready master port toward the memory-side
//   interface, tagged with its queue id.
// - Keeps per-queue saturating counters of dispatched entries for bandwidth monitoring.
// PARAMETERS
// - NUMBER_OF_QUEUES  4   number of request queues; must be >= 2
// - DATA_WIDTH        64  width of one queue entry
// - COUNTER_WIDTH     32  width of each per-queue dispatch counter
// PORTS
// - clock            in   1                              single clock; all logic on rising edge
// - reset            in   1                              synchronous, active-high
// - empty            in   NUMBER_OF_QUEUES               per-queue empty flag (1 = empty)
// - queue_data       in   NUMBER_OF_QUEUES*DATA_WIDTH    FWFT head of each queue; valid when empty[i]=0
// - sched_valid      in   1                              selector has a candidate
// - sched_selection  in   $clog2(NUMBER_OF_QUEUES)       selected queue index
// - pop              out  NUMBER_OF_QUEUES               one-hot read strobe to the queues
// - m_valid          out  1                              dispatched entry valid
// - m_data           out  DATA_WIDTH                     dispatched entry
// - m_queue_id       out  $clog2(NUMBER_OF_QUEUES)       source queue of m_data
// - m_ready          in   1                              consumer accepts when m_valid & m_ready
// - served           out  NUMBER_OF_QUEUES*COUNTER_WIDTH per-queue dispatch count, saturating
// BEHAVIOUR
// - Reset values: state=IDLE; pop=0; m_valid=0; m_data=0; m_queue_id=0; served=all 0.
//   Reset mid-transfer drops m_valid with no handshake and does not pop.
// - FSM has two states, IDLE and SEND.
// - IDLE -> SEND when sched_valid=1, sched_selection<NUMBER_OF_QUEUES and
//   empty[sched_selection]=0. On that edge:
//   - m_data <= queue_data[sel]; m_queue_id <= sel; m_valid <= 1
//   - pop <= onehot(sel), registered
//   - served[sel] increments, holding at 2^COUNTER_WIDTH-1
// - Otherwise IDLE holds and all outputs hold. An out-of-range sched_selection is ignored.
// - pop is high for exactly one cycle: the first SEND cycle. It is 0 in every other cycle.
// - SEND -> IDLE on the edge where m_valid & m_ready.
//   - m_valid falls on that edge; m_data and m_queue_id keep their last value.
// - In SEND, m_data and m_queue_id are stable until the handshake (AXI-style):
//   - no retraction while m_ready is low
//   - sched_* and empty are ignored
// - Latency: accepted selection at edge N -> m_valid=1 and pop=1 during cycle N+1.
// - Throughput: at most one dispatch per 2 cycles, because IDLE always lasts >= 1 cycle.
//   This guarantees empty reflects the previous pop before the next selection is sampled.
// - m_ready high in the first SEND cycle: pop and the handshake happen in the same cycle.
//   This is legal.
// - No combinational path from any input to pop or m_valid. m_data is registered.
// TESTING
// - Dispatch: queue 2 holds 0xA5, empty=4'b1011, sched_valid=1, sel=2, m_ready=1
//   -> pop=4'b0100 for 1 cycle, m_valid=1 with m_data=0xA5 and m_queue_id=2 one cycle after
//      acceptance, served[2]=1.
// - Backpressure: m_ready=0 for 5 cycles after dispatch
//   -> m_valid, m_data and m_queue_id stable, pop high only in the first SEND cycle,
//      no second pop; raising m_ready completes the transfer and returns the FSM to IDLE.
// - Back-to-back: two entries in queue 0, sched held valid on sel=0, m_ready=1
//   -> two pops exactly 2 cycles apart, data delivered in FIFO order, served[0]=2.
// - Guards: sched_valid=1 with empty[sel]=1, or sel out of range (drive NUMBER_OF_QUEUES=3, sel=3)
//   -> no pop, m_valid stays 0, counters unchanged.
// - Saturation: COUNTER_WIDTH=2, 5 dispatches from queue 1 -> served[1]=3.
// - Reset in SEND with m_ready=0 -> next cycle m_valid=0, pop=0, served=all 0, FSM in IDLE.

Source files
------------

// File: rtl/queue_dispatcher_if.sv
// Connection bundle between the queue dispatcher, its FWFT request queues, the selector
// and the memory-side consumer.
interface queue_dispatcher_if #(
   parameter int NUMBER_OF_QUEUES = 4,
   parameter int DATA_WIDTH       = 64,
   parameter int COUNTER_WIDTH    = 32
);
   localparam int SEL_WIDTH = $clog2(NUMBER_OF_QUEUES);

   logic [NUMBER_OF_QUEUES-1:0]               empty;
   logic [NUMBER_OF_QUEUES*DATA_WIDTH-1:0]    queue_data;
   logic                                      sched_valid;
   logic [SEL_WIDTH-1:0]                      sched_selection;
   logic [NUMBER_OF_QUEUES-1:0]               pop;
   logic                                      m_valid;
   logic [DATA_WIDTH-1:0]                     m_data;
   logic [SEL_WIDTH-1:0]                      m_queue_id;
   logic                                      m_ready;
   logic [NUMBER_OF_QUEUES*COUNTER_WIDTH-1:0] served;

   modport master (
      input  empty, queue_data, sched_valid, sched_selection, m_ready,
      output pop, m_valid, m_data, m_queue_id, served
   );

   modport slave (
      output empty, queue_data, sched_valid, sched_selection, m_ready,
      input  pop, m_valid, m_data, m_queue_id, served
   );
endinterface

// File: rtl/queue_dispatcher.sv
// Pops the queue picked by the selector, holds the entry on a valid/ready master port
// until accepted, and keeps saturating per-queue dispatch counts.
module queue_dispatcher #(
   parameter int NUMBER_OF_QUEUES = 4,
   parameter int DATA_WIDTH       = 64,
   parameter int COUNTER_WIDTH    = 32
) (
   input logic                clock,
   input logic                reset,
   queue_dispatcher_if.master bus
);
   localparam int SEL_WIDTH = $clog2(NUMBER_OF_QUEUES);
   localparam logic [SEL_WIDTH-1:0] LAST_QUEUE = SEL_WIDTH'(NUMBER_OF_QUEUES - 1);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t                      state_reg, state_next;
   logic [NUMBER_OF_QUEUES-1:0] pop_reg, pop_next;
   logic                        m_valid_reg, m_valid_next;
   logic [DATA_WIDTH-1:0]       m_data_reg, m_data_next;
   logic [SEL_WIDTH-1:0]        m_queue_id_reg, m_queue_id_next;
   logic [DATA_WIDTH-1:0]       head [NUMBER_OF_QUEUES];
   logic                        sel_in_range;
   logic                        accept;

   genvar gi;
   generate
      for (gi = 0; gi < NUMBER_OF_QUEUES; gi++) begin : g_head
         assign head[gi] = bus.queue_data[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   assign sel_in_range = (bus.sched_selection <= LAST_QUEUE);

   // Only IDLE samples the selector, so empty always reflects the previous pop.
   assign accept = (state_reg == IDLE) && bus.sched_valid && sel_in_range
                   && !bus.empty[bus.sched_selection];

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg      <= IDLE;
         pop_reg        <= '0;
         m_valid_reg    <= 1'b0;
         m_data_reg     <= '0;
         m_queue_id_reg <= '0;
      end else begin
         state_reg      <= state_next;
         pop_reg        <= pop_next;
         m_valid_reg    <= m_valid_next;
         m_data_reg     <= m_data_next;
         m_queue_id_reg <= m_queue_id_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      pop_next        = '0;
      m_valid_next    = m_valid_reg;
      m_data_next     = m_data_reg;
      m_queue_id_next = m_queue_id_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next      = SEND;
               pop_next        = NUMBER_OF_QUEUES'(1) << bus.sched_selection;
               m_valid_next    = 1'b1;
               m_data_next     = head[bus.sched_selection];
               m_queue_id_next = bus.sched_selection;
            end
         end
         SEND: begin
            // Payload is frozen until the consumer takes it.
            if (bus.m_ready) begin
               state_next   = IDLE;
               m_valid_next = 1'b0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   generate
      for (gi = 0; gi < NUMBER_OF_QUEUES; gi++) begin : g_served
         logic [COUNTER_WIDTH-1:0] count_reg;
         logic                     hit;

         assign hit = accept && (bus.sched_selection == SEL_WIDTH'(gi));

         always_ff @(posedge clock) begin
            if (reset) begin
               count_reg <= '0;
            end else if (hit && (count_reg != '1)) begin
               count_reg <= count_reg + COUNTER_WIDTH'(1);
            end
         end

         assign bus.served[gi*COUNTER_WIDTH +: COUNTER_WIDTH] = count_reg;
      end
   endgenerate

   assign bus.pop        = pop_reg;
   assign bus.m_valid    = m_valid_reg;
   assign bus.m_data     = m_data_reg;
   assign bus.m_queue_id = m_queue_id_reg;
endmodule

// File: tb/tb_queue_dispatcher.sv
// Randomised and directed bench for queue_dispatcher, checked against a transaction-level
// model built on FIFO queues.
module tb_queue_dispatcher;
   localparam int NQ   = 4;
   localparam int DW   = 64;
   localparam int CW   = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic clock = 1'b0;
   logic reset;
   logic reset3;
   always #5 clock = ~clock;

   queue_dispatcher_if #(.NUMBER_OF_QUEUES(NQ), .DATA_WIDTH(DW), .COUNTER_WIDTH(CW)) bus ();
   queue_dispatcher_if #(.NUMBER_OF_QUEUES(3), .DATA_WIDTH(16), .COUNTER_WIDTH(4)) bus3 ();

   queue_dispatcher #(.NUMBER_OF_QUEUES(NQ), .DATA_WIDTH(DW), .COUNTER_WIDTH(CW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   queue_dispatcher #(.NUMBER_OF_QUEUES(3), .DATA_WIDTH(16), .COUNTER_WIDTH(4)) dut3 (
      .clock (clock),
      .reset (reset3),
      .bus   (bus3)
   );

   int total = 0;
   int bad   = 0;

   // Reference: FIFO contents per queue plus the entry currently on offer.
   logic [DW-1:0] fifo [NQ][$];
   bit            mdl_busy;
   logic [DW-1:0] mdl_data;
   int            mdl_id;
   logic [NQ-1:0] mdl_pop;
   int            mdl_cnt [NQ];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic drive_queues();
      for (int i = 0; i < NQ; i++) begin
         bus.empty[i] = (fifo[i].size() == 0);
         bus.queue_data[i*DW +: DW] = (fifo[i].size() != 0) ? fifo[i][0] : (64'hDEAD_0000 + 64'(i));
      end
   endtask

   task automatic compare_all();
      chk("pop", 64'(bus.pop), 64'(mdl_pop));
      chk("m_valid", 64'(bus.m_valid), 64'(mdl_busy));
      chk("m_data", bus.m_data, mdl_data);
      chk("m_queue_id", 64'(bus.m_queue_id), 64'(mdl_id));
      for (int i = 0; i < NQ; i++)
         chk($sformatf("served[%0d]", i), 64'(bus.served[i*CW +: CW]), 64'(mdl_cnt[i]));
   endtask

   // One clock cycle: drive at negedge, predict, clock, check at next negedge.
   task automatic step(input bit sv, input logic [1:0] sel, input bit rdy, input bit rst);
      bit            nb;
      logic [DW-1:0] nd;
      int            nid;
      logic [NQ-1:0] np;
      int            nc [NQ];
      reset               = rst;
      bus.sched_valid     = sv;
      bus.sched_selection = sel;
      bus.m_ready         = rdy;
      drive_queues();
      nb  = mdl_busy;
      nd  = mdl_data;
      nid = mdl_id;
      np  = '0;
      nc  = mdl_cnt;
      if (rst) begin
         nb  = 0;
         nd  = '0;
         nid = 0;
         for (int i = 0; i < NQ; i++) nc[i] = 0;
      end else if (!mdl_busy) begin
         if (sv && fifo[sel].size() > 0) begin
            nb      = 1;
            nd      = fifo[sel][0];
            nid     = int'(sel);
            np      = 4'b0001 << sel;
            nc[sel] = (mdl_cnt[sel] + 1 > CMAX) ? CMAX : mdl_cnt[sel] + 1;
         end
      end else if (rdy) begin
         nb = 0;
         $display("xfer queue=%0d data=%h", mdl_id, mdl_data);
      end
      @(posedge clock);
      for (int i = 0; i < NQ; i++)
         if (mdl_pop[i]) void'(fifo[i].pop_front());
      mdl_busy = nb;
      mdl_data = nd;
      mdl_id   = nid;
      mdl_pop  = np;
      mdl_cnt  = nc;
      @(negedge clock);
      drive_queues();
      compare_all();
   endtask

   initial begin
      int c1, c2;
      int cyc;
      logic [DW-1:0] d1, d2;

      reset = 1'b1;
      reset3 = 1'b1;
      bus.sched_valid = 1'b0;
      bus.sched_selection = '0;
      bus.m_ready = 1'b0;
      mdl_busy = 0;
      mdl_data = '0;
      mdl_id = 0;
      mdl_pop = '0;
      for (int i = 0; i < NQ; i++) mdl_cnt[i] = 0;
      drive_queues();
      bus3.empty = '0;
      bus3.queue_data = {16'h3333, 16'h2222, 16'h1111};
      bus3.sched_valid = 1'b0;
      bus3.sched_selection = '0;
      bus3.m_ready = 1'b1;
      repeat (2) @(negedge clock);

      // Three-queue instance: selection 3 is out of range and must be ignored.
      reset3 = 1'b0;
      bus3.sched_valid = 1'b1;
      bus3.sched_selection = 2'd3;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         chk("range_pop", 64'(bus3.pop), 64'd0);
         chk("range_valid", 64'(bus3.m_valid), 64'd0);
         chk("range_served", 64'(bus3.served), 64'd0);
      end
      bus3.sched_selection = 2'd1;
      @(negedge clock);
      chk("range_ok_pop", 64'(bus3.pop), 64'b010);
      chk("range_ok_data", 64'(bus3.m_data), 64'h2222);
      chk("range_ok_id", 64'(bus3.m_queue_id), 64'd1);
      bus3.sched_valid = 1'b0;
      reset3 = 1'b1;

      // Reset state
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      chk("rst_served", 64'(bus.served), 64'd0);
      chk("rst_valid", 64'(bus.m_valid), 64'd0);

      // Single dispatch from queue 2
      fifo[2].push_back(64'hA5);
      step(1, 2'd2, 1, 0);
      chk("disp_pop", 64'(bus.pop), 64'b0100);
      chk("disp_data", bus.m_data, 64'hA5);
      chk("disp_id", 64'(bus.m_queue_id), 64'd2);
      step(0, 0, 1, 0);
      chk("disp_served2", 64'(bus.served[2*CW +: CW]), 64'd1);
      chk("disp_pop_once", 64'(bus.pop), 64'd0);

      // Backpressure with a second entry waiting behind the first
      fifo[3].push_back(64'h1234);
      fifo[3].push_back(64'h5678);
      step(1, 2'd3, 0, 0);
      repeat (5) step(1, 2'd3, 0, 0);
      chk("bp_pop", 64'(bus.pop), 64'd0);
      chk("bp_valid", 64'(bus.m_valid), 64'd1);
      chk("bp_data", bus.m_data, 64'h1234);
      step(0, 0, 1, 0);
      chk("bp_done", 64'(bus.m_valid), 64'd0);

      // Back-to-back from queue 0
      fifo[0].push_back(64'h111);
      fifo[0].push_back(64'h222);
      c1 = -1; c2 = -1; d1 = '0; d2 = '0;
      for (int k = 0; k < 6; k++) begin
         step(1, 2'd0, 1, 0);
         if (bus.pop[0]) begin
            if (c1 < 0) begin c1 = k; d1 = bus.m_data; end
            else if (c2 < 0) begin c2 = k; d2 = bus.m_data; end
         end
      end
      chk("b2b_gap", 64'(c2 - c1), 64'd2);
      chk("b2b_first", d1, 64'h111);
      chk("b2b_second", d2, 64'h222);
      chk("b2b_served0", 64'(bus.served[0*CW +: CW]), 64'd2);

      // Empty guard: queue 1 holds nothing
      repeat (3) step(1, 2'd1, 1, 0);
      chk("guard_pop", 64'(bus.pop), 64'd0);
      chk("guard_valid", 64'(bus.m_valid), 64'd0);
      chk("guard_served1", 64'(bus.served[1*CW +: CW]), 64'd0);

      // Saturation: five dispatches into a 2-bit counter
      step(0, 0, 0, 1);
      for (int k = 0; k < 5; k++) fifo[1].push_back(64'h100 + 64'(k));
      repeat (12) step(1, 2'd1, 1, 0);
      chk("sat_served1", 64'(bus.served[1*CW +: CW]), 64'd3);

      // Reset while an entry is stuck in SEND
      fifo[2].push_back(64'hBEEF);
      step(1, 2'd2, 0, 0);
      step(1, 2'd2, 0, 0);
      step(0, 0, 0, 1);
      chk("rst_send_valid", 64'(bus.m_valid), 64'd0);
      chk("rst_send_pop", 64'(bus.pop), 64'd0);
      chk("rst_send_served", 64'(bus.served), 64'd0);

      // Random traffic
      for (int i = 0; i < NQ; i++) fifo[i].delete();
      step(0, 0, 0, 1);
      for (cyc = 0; cyc < 2000; cyc++) begin
         for (int i = 0; i < NQ; i++)
            if (($urandom % 4 == 0) && fifo[i].size() < 8)
               fifo[i].push_back({$urandom, $urandom});
         step(($urandom % 3) != 0, 2'($urandom % 4), ($urandom % 3) != 0, ($urandom % 200) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
